// File: rtl/rv_fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch front end.
// Optional combinational response bypass is enabled with FETCH_BYPASS_EN.
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          MEM_LAT_MAX = 4;
    localparam int          FETCH_XLEN  = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; flush and reset take priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  buf_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (!push && pop)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            buf_q[wr_ptr] <= push_data;
    end

    assign head = buf_q[rd_ptr];

endmodule

// File: rtl/rv_fetch_unit.sv
// Fetch front end: PC, credit-based request issue, in-flight tag pipe, prefetch FIFO.
// Define FETCH_BYPASS_EN to present a response to decode in its arrival cycle when the FIFO is empty.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MEM_LAT  = 1,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [XLEN-1:0]             imem_addr,
    output logic                        imem_req,
    input  logic [31:0]                 imem_rdata,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        d_ready,
    output logic                        d_valid,
    output logic [31:0]                 d_instr,
    output logic [XLEN-1:0]             d_pc,
    output logic [XLEN-1:0]             d_pc_plus_4,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);
    localparam int STAGES = MEM_LAT - 1;
    localparam int CW     = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [XLEN-1:0]             pc;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][XLEN-1:0]   pc_pipe;
    logic [CW-1:0]               inflight_cnt;
    logic [CW:0]                 credit_use;
    logic                        resp_vld;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    entry_t                      resp;
    entry_t                      head;
    entry_t                      sel;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= STAGES; i++)
            inflight_cnt = inflight_cnt + CW'(vld_pipe[i]);
    end

    // Every outstanding request owns a FIFO slot, so a response can always be pushed.
    assign credit_use = {1'b0, inflight_cnt} + {1'b0, fq_count};
    assign imem_req   = !reset && (credit_use < (CW+1)'(FQ_DEPTH));
    assign imem_addr  = pc;

    assign resp_vld   = vld_pipe[STAGES] && !redirect_valid && !reset;
    assign resp       = '{pc: pc_pipe[STAGES], instr: imem_rdata};
    assign fifo_empty = (fq_count == '0);
    assign pop        = !fifo_empty && d_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass  = fifo_empty && resp_vld;
    assign d_valid = !fifo_empty || bypass;
    assign sel     = bypass ? resp : head;
    assign push    = resp_vld && !(bypass && d_ready);
`else
    assign d_valid = !fifo_empty;
    assign sel     = head;
    assign push    = resp_vld;
`endif

    assign d_instr     = d_valid ? sel.instr : NOP_INSTR;
    assign d_pc        = d_valid ? sel.pc : '0;
    assign d_pc_plus_4 = d_pc + XLEN'(4);

    // A redirect kills the tags already in flight and the one issued this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            vld_pipe <= '0;
            pc_pipe  <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            vld_pipe <= '0;
        end else begin
            if (imem_req)
                pc <= pc + XLEN'(4);
            vld_pipe[0] <= imem_req;
            pc_pipe[0]  <= pc;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pc_pipe[i]  <= pc_pipe[i-1];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (resp),
        .pop       (pop),
        .head      (head),
        .count     (fq_count)
    );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomised bench for rv_fetch_unit against a queue-based model of the fetch front end.
module tb_rv_fetch_unit;

    localparam int          LAT = 3;
    localparam int          FQD = 8;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        d_ready = 1'b0;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc_plus_4;
    logic [$clog2(FQD):0] fq_count;

    rv_fetch_unit #(
        .XLEN(32), .RESET_PC(RPC), .MEM_LAT(LAT), .FQ_DEPTH(FQD)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .d_ready(d_ready), .d_valid(d_valid), .d_instr(d_instr),
        .d_pc(d_pc), .d_pc_plus_4(d_pc_plus_4), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int cyc = 0;

    // Environment: memory returns the word for the address requested LAT cycles ago.
    bit          mem_v [LAT];
    logic [31:0] mem_a [LAT];

    // Model state: PC, outstanding requests with arrival cycle, prefetch queue.
    typedef struct { int unsigned pc; int due; } infl_t;
    typedef struct { int unsigned pc; int unsigned instr; } ent_t;
    int unsigned m_pc;
    infl_t       infl_q[$];
    ent_t        fq_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit          e_req, e_dv, resp_ok, byp;
        ent_t        r_ent, e_ent;
        logic [31:0] e_pc;
        logic        s_req;
        logic [31:0] s_addr;

        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        d_ready        = rdy;
        imem_rdata     = mem_v[LAT-1] ? mem_word(mem_a[LAT-1]) : $urandom;
        #1;

        resp_ok = !rst && !rv && infl_q.size() > 0 && infl_q[0].due == cyc;
        if (infl_q.size() > 0)
            r_ent = '{pc: infl_q[0].pc, instr: mem_word(infl_q[0].pc)};
        else
            r_ent = '{pc: 0, instr: 0};
        e_req = !rst && (infl_q.size() + fq_q.size() < FQD);
        byp   = BYP && fq_q.size() == 0 && resp_ok;
        e_dv  = fq_q.size() > 0 || byp;
        e_ent = fq_q.size() > 0 ? fq_q[0] : r_ent;
        e_pc  = e_dv ? e_ent.pc : 32'h0;

        if (check_en) begin
            chk("imem_req",  {31'h0, imem_req}, {31'h0, e_req});
            chk("imem_addr", imem_addr, m_pc);
            chk("d_valid",   {31'h0, d_valid}, {31'h0, e_dv});
            chk("d_pc",      d_pc, e_pc);
            chk("d_instr",   d_instr, e_dv ? e_ent.instr : NOP);
            chk("d_pc_p4",   d_pc_plus_4, e_pc + 32'd4);
            chk("fq_count",  32'(fq_count), 32'(fq_q.size()));
        end
        s_req  = imem_req;
        s_addr = imem_addr;

        @(posedge clk);
        for (int i = LAT-1; i > 0; i--) begin
            mem_v[i] = mem_v[i-1];
            mem_a[i] = mem_a[i-1];
        end
        mem_v[0] = s_req;
        mem_a[0] = s_addr;

        if (rst) begin
            m_pc = RPC;
            infl_q.delete();
            fq_q.delete();
        end else if (rv) begin
            m_pc = rpc & ~32'h3;
            infl_q.delete();
            fq_q.delete();
        end else begin
            if (e_dv && rdy && fq_q.size() > 0)
                void'(fq_q.pop_front());
            if (resp_ok) begin
                void'(infl_q.pop_front());
                if (!(byp && rdy))
                    fq_q.push_back(r_ent);
            end
            if (e_req) begin
                infl_q.push_back('{pc: m_pc, due: cyc + LAT});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            mem_v[i] = 1'b0;
            mem_a[i] = '0;
        end
        m_pc = RPC;

        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_en = 1'b1;
        step(1, 0, 0, 1);

        // Streaming, then back-pressure to saturation, then resume.
        repeat (40) step(0, 0, 0, 1);
        repeat (15) step(0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 1);

        // Redirect with requests in flight and entries queued.
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        repeat (12) step(0, 0, 0, 1);

        // Back-to-back redirects: only the second target survives.
        step(0, 1, 32'h40, 1);
        step(0, 1, 32'h80, 1);
        repeat (12) step(0, 0, 0, 1);

        // Full FIFO with push+pop, then an unaligned redirect target.
        repeat (14) step(0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1);
        step(0, 1, 32'h103, 1);
        repeat (10) step(0, 0, 0, 1);

        // PC wrap-around at the top of the address space.
        step(0, 1, 32'hFFFF_FFF4, 1);
        repeat (12) step(0, 0, 0, 1);

        // Reset mid-stream with responses in flight.
        repeat (5) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1);

        repeat (3000) begin
            logic        r_rst, r_rv, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rv  = ($urandom_range(0, 99) < 4);
            r_rdy = ($urandom_range(0, 99) < 70);
            r_pc  = $urandom & 32'h0000_0FFF;
            step(r_rst, r_rv, r_pc, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
